counter_bank: RTL and testbench



---
 rtl/counter_bank.sv | 91 +++++++++
 tb/tb_counter_bank.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/counter_bank.sv
// Bank of independent per-channel up-counters with load/clear, wrap-or-saturate and a tc pulse.
// Latency: count and tc one cycle after the sampled request; rd_val combinational. No backpressure.

module counter_chan #(
  parameter int WIDTH    = 8,
  parameter int SATURATE = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt,
  output logic             tc
);

  localparam logic [WIDTH-1:0] MAX = '1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      tc  <= 1'b0;
    end else begin
      tc <= 1'b0;
      if (clear) begin
        cnt <= '0;
      end else if (load) begin
        cnt <= load_val;
      end else if (inc) begin
        if (cnt != MAX) begin
          cnt <= cnt + 1'b1;
          // Saturating counters flag the edge that reaches MAX, not the ones that stick there.
          tc  <= (SATURATE != 0) && (cnt == (MAX - 1'b1));
        end else if (SATURATE == 0) begin
          cnt <= '0;
          tc  <= 1'b1;
        end
      end
    end
  end

endmodule

module counter_bank #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SATURATE = 0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                clear,
  input  logic [CHANNELS-1:0] inc,
  input  logic                load_en,
  input  logic [3:0]          load_chan,
  input  logic [WIDTH-1:0]    load_val,
  input  logic [3:0]          rd_chan,
  output logic [WIDTH-1:0]    rd_val,
  output logic [CHANNELS-1:0] tc
);

  logic [WIDTH-1:0] cnt [CHANNELS];

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    logic load_hit;
    assign load_hit = load_en && (load_chan == 4'(g));

    counter_chan #(
      .WIDTH    (WIDTH),
      .SATURATE (SATURATE)
    ) u_chan (
      .clock    (clock),
      .reset    (reset),
      .clear    (clear),
      .load     (load_hit),
      .load_val (load_val),
      .inc      (inc[g]),
      .cnt      (cnt[g]),
      .tc       (tc[g])
    );
  end

  // Unpopulated channel numbers read back as zero.
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (rd_chan == 4'(i)) rd_val = cnt[i];
    end
  end

endmodule

// File: tb/tb_counter_bank.sv
// Drives a wrapping and a saturating counter_bank with the same directed stimulus and scoreboards both.

module tb_counter_bank;

  logic       clock = 1'b0;
  logic       reset;
  logic       clear;
  logic [3:0] inc;
  logic       load_en;
  logic [3:0] load_chan;
  logic [7:0] load_val;
  logic [3:0] rd_chan;
  logic [7:0] rd_val_w, rd_val_s;
  logic [3:0] tc_w, tc_s;

  int compared   = 0;
  int mismatched = 0;

  typedef struct packed {
    logic [7:0] rd_w;
    logic [7:0] rd_s;
    logic [3:0] tc_w;
    logic [3:0] tc_s;
  } exp_t;

  exp_t exp_q[$];

  // Reference state: index 0 = wrapping bank, 1 = saturating bank.
  logic [7:0] m_cnt [2][4];
  logic [3:0] m_tc  [2];

  always #5 clock = ~clock;

  counter_bank #(.WIDTH(8), .CHANNELS(4), .SATURATE(0)) u_wrap (
    .clock(clock), .reset(reset), .clear(clear), .inc(inc),
    .load_en(load_en), .load_chan(load_chan), .load_val(load_val),
    .rd_chan(rd_chan), .rd_val(rd_val_w), .tc(tc_w)
  );

  counter_bank #(.WIDTH(8), .CHANNELS(4), .SATURATE(1)) u_sat (
    .clock(clock), .reset(reset), .clear(clear), .inc(inc),
    .load_en(load_en), .load_chan(load_chan), .load_val(load_val),
    .rd_chan(rd_chan), .rd_val(rd_val_s), .tc(tc_s)
  );

  initial begin
    #50000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    compared++;
    assert (got === want) else begin
      mismatched++;
      $error("FAIL %s got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < 2; b++) begin
      for (int c = 0; c < 4; c++) m_cnt[b][c] = 8'd0;
      m_tc[b] = 4'd0;
    end
  endtask

  function automatic logic [7:0] model_rd(input int b, input logic [3:0] ch);
    return (ch < 4'd4) ? m_cnt[b][ch[1:0]] : 8'd0;
  endfunction

  task automatic model_edge();
    for (int b = 0; b < 2; b++) begin
      m_tc[b] = 4'd0;
      for (int c = 0; c < 4; c++) begin
        if (clear) begin
          m_cnt[b][c] = 8'd0;
        end else if (load_en && load_chan == 4'(c)) begin
          m_cnt[b][c] = load_val;
        end else if (inc[c]) begin
          if (m_cnt[b][c] == 8'hFF) begin
            if (b == 0) begin
              m_cnt[b][c] = 8'd0;
              m_tc[b][c]  = 1'b1;
            end
          end else begin
            if (b == 1 && m_cnt[b][c] == 8'hFE) m_tc[b][c] = 1'b1;
            m_cnt[b][c] = m_cnt[b][c] + 8'd1;
          end
        end
      end
    end
  endtask

  // Called just after a rising edge: drive, predict, clock, compare.
  task automatic step(input string tag, input logic [3:0] i_inc, input logic i_load,
                      input logic [3:0] i_lch, input logic [7:0] i_lval,
                      input logic i_clr, input logic [3:0] i_rd);
    exp_t e;
    exp_t got;
    inc = i_inc; load_en = i_load; load_chan = i_lch; load_val = i_lval;
    clear = i_clr; rd_chan = i_rd;
    model_edge();
    e.rd_w = model_rd(0, i_rd);
    e.rd_s = model_rd(1, i_rd);
    e.tc_w = m_tc[0];
    e.tc_s = m_tc[1];
    exp_q.push_back(e);
    @(posedge clock);
    #1;
    got = exp_q.pop_front();
    chk({tag, ".rd_wrap"}, 32'(rd_val_w), 32'(got.rd_w));
    chk({tag, ".rd_sat"},  32'(rd_val_s), 32'(got.rd_s));
    chk({tag, ".tc_wrap"}, 32'(tc_w),     32'(got.tc_w));
    chk({tag, ".tc_sat"},  32'(tc_s),     32'(got.tc_s));
    inc = 4'd0; load_en = 1'b0; clear = 1'b0;
  endtask

  task automatic check_all(input string tag);
    for (int c = 0; c < 4; c++) begin
      rd_chan = 4'(c);
      #1;
      chk($sformatf("%s.ch%0d_wrap", tag, c), 32'(rd_val_w), 32'(model_rd(0, 4'(c))));
      chk($sformatf("%s.ch%0d_sat",  tag, c), 32'(rd_val_s), 32'(model_rd(1, 4'(c))));
    end
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; inc = 4'd0; load_en = 1'b0;
    load_chan = 4'd0; load_val = 8'd0; rd_chan = 4'd0;
    model_reset();
    #12;
    reset = 1'b0;
    chk("reset.rd_wrap", 32'(rd_val_w), 32'd0);
    chk("reset.tc_sat",  32'(tc_s),     32'd0);
    @(posedge clock); #1;

    // Build nonzero counts, then reset asynchronously mid-cycle.
    for (int k = 0; k < 3; k++) step("prefill", 4'b1111, 1'b0, 4'd0, 8'd0, 1'b0, 4'd3);
    chk("prefill.lit", 32'(rd_val_w), 32'd3);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    chk("async_reset.rd_wrap", 32'(rd_val_w), 32'd0);
    chk("async_reset.rd_sat",  32'(rd_val_s), 32'd0);
    chk("async_reset.tc_wrap", 32'(tc_w),     32'd0);
    check_all("async_reset");
    reset = 1'b0;
    @(posedge clock); #1;

    // Wrap at MAX on channel 2.
    step("wrap_load", 4'b0000, 1'b1, 4'd2, 8'd254, 1'b0, 4'd2);
    step("wrap_inc1", 4'b0100, 1'b0, 4'd0, 8'd0,   1'b0, 4'd2);
    chk("wrap_inc1.lit", 32'(rd_val_w), 32'd255);
    step("wrap_inc2", 4'b0100, 1'b0, 4'd0, 8'd0,   1'b0, 4'd2);
    chk("wrap_inc2.lit_rd", 32'(rd_val_w), 32'd0);
    chk("wrap_inc2.lit_tc", 32'(tc_w),     32'b0100);
    step("wrap_inc3", 4'b0100, 1'b0, 4'd0, 8'd0,   1'b0, 4'd2);
    chk("wrap_inc3.lit", 32'(rd_val_w), 32'd1);

    // Saturate on channel 1.
    step("sat_load", 4'b0000, 1'b1, 4'd1, 8'd253, 1'b0, 4'd1);
    for (int k = 0; k < 4; k++) step($sformatf("sat_inc%0d", k), 4'b0010, 1'b0, 4'd0, 8'd0, 1'b0, 4'd1);
    chk("sat_hold.lit_rd", 32'(rd_val_s), 32'd255);
    chk("sat_hold.lit_tc", 32'(tc_s),     32'd0);

    // Load beats increment, clear beats load.
    step("prio_load10", 4'b0000, 1'b1, 4'd0, 8'd10, 1'b0, 4'd0);
    step("prio_load77", 4'b0001, 1'b1, 4'd0, 8'd77, 1'b0, 4'd0);
    chk("prio_load77.lit", 32'(rd_val_w), 32'd77);
    step("prio_clear",  4'b0000, 1'b1, 4'd0, 8'd55, 1'b1, 4'd0);
    check_all("prio_clear");

    // Independence and out-of-range selects.
    for (int k = 0; k < 5; k++) step("indep", 4'b1111, 1'b0, 4'd0, 8'd0, 1'b0, 4'd3);
    check_all("indep");
    step("oor_load", 4'b0000, 1'b1, 4'd9, 8'd3, 1'b0, 4'd0);
    check_all("oor_load");
    rd_chan = 4'd12;
    #1;
    chk("oor_rd_wrap", 32'(rd_val_w), 32'd0);
    chk("oor_rd_sat",  32'(rd_val_s), 32'd0);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
